// File: rtl/nfc_page_wbuf.sv
// rtl/nfc_page_wbuf.sv - ping-pong NAND page write buffer into dual-port RAM port A; NFC_WBUF_PACK_EN enables byte-pair packing
module nfc_page_wbuf #(
    parameter int          PAGE_BYTES = 4608,
    parameter logic [12:0] BANK1_BASE = 13'd2304
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_vld,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    output logic        byte_rdy,
    output logic [12:0] dpram_addra,
    output logic        dpram_cena,
    output logic [1:0]  dpram_wena,
    output logic [15:0] dpram_dina,
    output logic [1:0]  buf_full,
    output logic [12:0] buf_len0,
    output logic [12:0] buf_len1,
    output logic [1:0]  buf_trunc,
    input  logic [1:0]  buf_free
);

    localparam logic [12:0] PAGE_LIMIT = 13'(PAGE_BYTES);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CLOSE = 2'd2
    } state_t;

    state_t      state;
    logic        bank;
    logic [12:0] byte_cnt;
    logic        close_trunc;

    logic        accept;
    logic [12:0] cnt_inc;
    logic        page_end;
    logic [12:0] cur_base;
    logic [12:0] wr_addr;
    logic [1:0]  freed;
    logic [1:0]  full_after_free;
    logic        cur_bank_free;
    logic        next_bank_free;
    logic [1:0]  close_set;

`ifdef NFC_WBUF_PACK_EN
    logic [7:0]  pack_byte;
`endif

    // Acceptance, page-end detection, addressing and bank availability after this cycle's releases
    always_comb begin
        accept          = byte_vld & byte_rdy;
        cnt_inc         = byte_cnt + 13'd1;
        page_end        = byte_last | (cnt_inc == PAGE_LIMIT);
        cur_base        = bank ? BANK1_BASE : 13'd0;
        wr_addr         = cur_base + {1'b0, byte_cnt[12:1]};
        freed           = buf_free & buf_full;
        full_after_free = buf_full & ~freed;
        cur_bank_free   = ~full_after_free[bank];
        next_bank_free  = ~full_after_free[~bank];
        close_set       = 2'b00;
        if (state == ST_CLOSE) begin
            close_set = bank ? 2'b10 : 2'b01;
        end
    end

    // Write FSM: waits for the current bank, fills it, then spends one cycle closing it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_WAIT;
            byte_rdy    <= 1'b0;
            bank        <= 1'b0;
            byte_cnt    <= 13'd0;
            close_trunc <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (cur_bank_free) begin
                        state    <= ST_FILL;
                        byte_rdy <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        byte_cnt <= cnt_inc;
                        if (page_end) begin
                            state       <= ST_CLOSE;
                            byte_rdy    <= 1'b0;
                            close_trunc <= ~byte_last;
                        end
                    end
                end
                ST_CLOSE: begin
                    bank     <= ~bank;
                    byte_cnt <= 13'd0;
                    if (next_bank_free) begin
                        state    <= ST_FILL;
                        byte_rdy <= 1'b1;
                    end else begin
                        state    <= ST_WAIT;
                        byte_rdy <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_WAIT;
                    byte_rdy <= 1'b0;
                end
            endcase
        end
    end

    // RAM port A: one-cycle write strobe for each accepted byte (or byte pair when packing)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dpram_cena  <= 1'b1;
            dpram_wena  <= 2'b11;
            dpram_addra <= 13'd0;
            dpram_dina  <= 16'd0;
`ifdef NFC_WBUF_PACK_EN
            pack_byte   <= 8'd0;
`endif
        end else begin
            dpram_cena <= 1'b1;
            dpram_wena <= 2'b11;
            if (state == ST_FILL && accept) begin
`ifdef NFC_WBUF_PACK_EN
                if (byte_cnt[0]) begin
                    dpram_cena  <= 1'b0;
                    dpram_wena  <= 2'b00;
                    dpram_addra <= wr_addr;
                    dpram_dina  <= {byte_data, pack_byte};
                end else begin
                    pack_byte <= byte_data;
                end
`else
                dpram_cena  <= 1'b0;
                dpram_wena  <= byte_cnt[0] ? 2'b01 : 2'b10;
                dpram_addra <= wr_addr;
                dpram_dina  <= {byte_data, byte_data};
`endif
            end
`ifdef NFC_WBUF_PACK_EN
            else if (state == ST_CLOSE && byte_cnt[0]) begin
                dpram_cena  <= 1'b0;
                dpram_wena  <= 2'b10;
                dpram_addra <= wr_addr;
                dpram_dina  <= {8'h00, pack_byte};
            end
`endif
        end
    end

    // Bank status: release on consumer pulse, mark full with length and truncation on close
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full  <= 2'b00;
            buf_trunc <= 2'b00;
            buf_len0  <= 13'd0;
            buf_len1  <= 13'd0;
        end else begin
            buf_full  <= full_after_free | close_set;
            buf_trunc <= (buf_trunc & ~freed & ~close_set) | (close_trunc ? close_set : 2'b00);
            if (state == ST_CLOSE) begin
                if (bank) begin
                    buf_len1 <= byte_cnt;
                end else begin
                    buf_len0 <= byte_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_nfc_page_wbuf.sv
// tb/tb_nfc_page_wbuf.sv - self-checking bench for nfc_page_wbuf against a page-level reference model
module tb_nfc_page_wbuf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        byte_vld;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        byte_rdy;
    logic [12:0] dpram_addra;
    logic        dpram_cena;
    logic [1:0]  dpram_wena;
    logic [15:0] dpram_dina;
    logic [1:0]  buf_full;
    logic [12:0] buf_len0;
    logic [12:0] buf_len1;
    logic [1:0]  buf_trunc;
    logic [1:0]  buf_free;

    always #5 clk = ~clk;

    nfc_page_wbuf dut (
        .clk(clk), .rst_n(rst_n),
        .byte_vld(byte_vld), .byte_data(byte_data), .byte_last(byte_last), .byte_rdy(byte_rdy),
        .dpram_addra(dpram_addra), .dpram_cena(dpram_cena), .dpram_wena(dpram_wena), .dpram_dina(dpram_dina),
        .buf_full(buf_full), .buf_len0(buf_len0), .buf_len1(buf_len1), .buf_trunc(buf_trunc),
        .buf_free(buf_free)
    );

    int n_chk = 0;
    int n_fail = 0;

    // reference model: expected outputs for the current cycle plus page progress
    logic        m_rdy, m_cena;
    logic [1:0]  m_wena;
    logic [12:0] m_addr;
    logic [15:0] m_dina, m_dmask;
    logic [1:0]  m_full, m_trunc;
    int          m_len [2];
    int          m_bank, m_cnt, m_close_len;
    bit          m_closing, m_close_trunc, m_acc;
    logic [7:0]  m_pack;

    int          last_wr_addr;
    logic [1:0]  last_wr_wena;
    int          first_wr_addr;
    bit          first_pending = 1'b0;
    int          rand_free_pct = 0;
    logic [7:0]  data_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rdy = 1'b0; m_cena = 1'b1; m_wena = 2'b11; m_addr = 13'd0; m_dina = 16'd0; m_dmask = 16'hffff;
        m_full = 2'b00; m_trunc = 2'b00; m_len[0] = 0; m_len[1] = 0;
        m_bank = 0; m_cnt = 0; m_close_len = 0; m_closing = 1'b0; m_close_trunc = 1'b0; m_acc = 1'b0;
        m_pack = 8'd0;
    endtask

    task automatic mwrite(input int a, input logic [1:0] w, input logic [15:0] d, input logic [15:0] mk);
        m_cena = 1'b0; m_wena = w; m_addr = 13'(a); m_dina = d; m_dmask = mk;
    endtask

    task automatic compare();
        check("byte_rdy", byte_rdy, m_rdy);
        check("cena", dpram_cena, m_cena);
        check("wena", dpram_wena, m_wena);
        if (!m_cena || !rst_n) begin
            check("addra", dpram_addra, m_addr);
            check("dina", dpram_dina & m_dmask, m_dina & m_dmask);
        end
        check("buf_full", buf_full, m_full);
        check("buf_trunc", buf_trunc, m_trunc);
        if (m_full[0] || !rst_n) check("buf_len0", buf_len0, m_len[0]);
        if (m_full[1] || !rst_n) check("buf_len1", buf_len1, m_len[1]);
        if (dpram_cena === 1'b0) begin
            last_wr_addr = dpram_addra;
            last_wr_wena = dpram_wena;
            if (first_pending) begin
                first_wr_addr = dpram_addra;
                first_pending = 1'b0;
            end
        end
    endtask

    // one clock: advance the model with what the DUT saw at the edge, then compare
    task automatic cyc();
        int base;
        @(posedge clk);
        @(negedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_acc = byte_vld && m_rdy;
            m_cena = 1'b1;
            m_wena = 2'b11;
            for (int b = 0; b < 2; b++) begin
                if (buf_free[b] && m_full[b]) begin
                    m_full[b] = 1'b0;
                    m_trunc[b] = 1'b0;
                end
            end
            base = (m_bank == 1) ? 2304 : 0;
            if (m_closing) begin
                m_full[m_bank] = 1'b1;
                m_len[m_bank] = m_close_len;
                m_trunc[m_bank] = m_close_trunc;
`ifdef NFC_WBUF_PACK_EN
                if (m_close_len % 2 == 1) mwrite(base + (m_close_len - 1) / 2, 2'b10, {8'h00, m_pack}, 16'h00ff);
`endif
                m_bank = 1 - m_bank;
                m_cnt = 0;
                m_closing = 1'b0;
            end else if (m_acc) begin
`ifdef NFC_WBUF_PACK_EN
                if (m_cnt % 2 == 0) m_pack = byte_data;
                else mwrite(base + m_cnt / 2, 2'b00, {byte_data, m_pack}, 16'hffff);
`else
                mwrite(base + m_cnt / 2, (m_cnt % 2 == 1) ? 2'b01 : 2'b10, {byte_data, byte_data}, 16'hffff);
`endif
                m_cnt++;
                if (byte_last || m_cnt == 4608) begin
                    m_closing = 1'b1;
                    m_close_len = m_cnt;
                    m_close_trunc = !byte_last;
                end
            end
            m_rdy = !m_closing && !m_full[m_bank];
        end
        compare();
        if (rand_free_pct > 0)
            buf_free = {($urandom_range(99) < rand_free_pct), ($urandom_range(99) < rand_free_pct)};
        else
            buf_free = 2'b00;
    endtask

    task automatic idle(input int n);
        byte_vld = 1'b0;
        byte_last = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic send_page(input int n, input bit with_last, input int gap_pct);
        int i = 0;
        int t = 0;
        while (i < n && t < 20000) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                byte_vld = 1'b0;
                byte_last = 1'b0;
            end else begin
                byte_vld = 1'b1;
                byte_data = (i < data_q.size()) ? data_q[i] : 8'($urandom);
                byte_last = with_last && (i == n - 1);
            end
            cyc();
            t++;
            if (m_acc) i++;
        end
        byte_vld = 1'b0;
        byte_last = 1'b0;
        data_q.delete();
        if (i < n) check("send_timeout", i, n);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; byte_vld = 1'b0; byte_data = 8'd0; byte_last = 1'b0; buf_free = 2'b00;
        model_reset();
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        check("rdy_after_reset", byte_rdy, 1);

        // page 1: four bytes into bank 0
        data_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        first_pending = 1'b1;
        send_page(4, 1'b1, 0);
        idle(2);
        check("p1_full", buf_full, 2'b01);
        check("p1_len0", buf_len0, 4);
        check("p1_model_len", m_len[0], 4);
        check("p1_first_addr", first_wr_addr, 0);
        check("p1_last_addr", last_wr_addr, 1);

        // page 2: three bytes into bank 1
        data_q = '{8'hA1, 8'hB2, 8'hC3};
        send_page(3, 1'b1, 0);
        idle(2);
        check("p2_last_addr", last_wr_addr, 2305);
        check("p2_last_wena", last_wr_wena, 2'b10);
        check("p2_len1", buf_len1, 3);
        check("p2_full", buf_full, 2'b11);

        // third page offered while both banks are held
        byte_vld = 1'b1; byte_data = 8'h5A; byte_last = 1'b0;
        repeat (5) cyc();
        check("held_rdy", byte_rdy, 0);
        buf_free = 2'b01;
        cyc();
        check("rdy_after_free", byte_rdy, 1);
        first_pending = 1'b1;
        data_q = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E};
        send_page(5, 1'b1, 0);
        idle(2);
        check("p3_first_addr", first_wr_addr, 0);
        check("p3_full", buf_full, 2'b11);

        // simultaneous release of both, then a release of a free bank
        buf_free = 2'b11;
        cyc();
        check("both_freed", buf_full, 2'b00);
        buf_free = 2'b01;
        cyc();
        idle(2);

        // partial page in bank 1 then reset mid-page
        send_page(10, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        check("rst_cena", dpram_cena, 1);
        check("rst_full", buf_full, 2'b00);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();

        // full-length page without byte_last auto-closes bank 0
        first_pending = 1'b1;
        send_page(4608, 1'b0, 0);
        idle(2);
        check("big_first_addr", first_wr_addr, 0);
        check("big_last_addr", last_wr_addr, 2303);
        check("big_trunc", buf_trunc, 2'b01);
        check("big_len0", buf_len0, 4608);

        // randomized traffic with random consumer releases
        buf_free = 2'b11;
        cyc();
        rand_free_pct = 15;
        for (int p = 0; p < 60; p++) begin
            send_page($urandom_range(1, 40), ($urandom_range(0, 9) != 0), 25);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end
        rand_free_pct = 0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nfc_page_wbuf.md
# nfc_page_wbuf

Ping-pong page write buffer sitting directly upstream of the NFC 4.5K×16 dual-port page RAM, driving its port A. It accepts the byte stream read from NAND (page data plus spare), writes each byte into one of two 2304-word banks, and hands each completed page to the downstream consumer (ECC/host side, on RAM port B) with its byte length. Back-pressure stalls the NAND byte stream when both banks are held by the consumer.

## Interface
- PAGE_BYTES, 4608, maximum bytes per page; a bank auto-closes at this count.
- BANK1_BASE, 13'd2304, word address of bank 1; bank 0 base is 0.
- clk  in  1  single clock for the block and RAM port A.
- rst_n  in  1  asynchronous, active-low reset.
- byte_vld  in  1  input byte valid.
- byte_data  in  8  input byte.
- byte_last  in  1  final byte of page, qualified by byte_vld.
- byte_rdy  out  1  block can accept a byte this cycle.
- dpram_addra  out  13  port A word address.
- dpram_cena  out  1  port A chip enable, active low.
- dpram_wena  out  2  port A byte write enables, active low; [0]=bits 7:0, [1]=bits 15:8.
- dpram_dina  out  16  port A write data.
- buf_full  out  2  bank b holds a complete page.
- buf_len0 / buf_len1  out  13  byte length of bank 0 / bank 1 page; valid while buf_full[b].
- buf_trunc  out  2  bank b closed by PAGE_BYTES limit with no byte_last.
- buf_free  in  2  one-cycle pulse from consumer releasing bank b.

## Operation
- Bank state per bank: FREE -> FILLING -> FULL -> FREE (on buf_free[b]).
- Write FSM: WAIT (current bank not FREE, byte_rdy=0) -> FILL (byte_rdy=1) -> CLOSE (one cycle: flush, set buf_full, toggle bank) -> WAIT or FILL.
- Starts on bank 0 after reset; banks used strictly alternately.
- Byte accepted when byte_vld & byte_rdy. byte_cnt (13 bit) counts bytes in current page; word address = base + byte_cnt[12:1], lane = byte_cnt[0] (even=low byte).
- Close when accepted byte has byte_last=1, or byte_cnt reaches PAGE_BYTES (buf_trunc[b] set). buf_len = byte count including last byte.
- buf_free[b] for a bank not FULL is ignored. Both bits may pulse together.
- byte_vld with byte_rdy=0: no effect, byte held by source.

## Timing
- Reset values: byte_rdy=0, dpram_cena=1, dpram_wena=2'b11, dpram_addra=0, dpram_dina=0, buf_full=0, buf_len0/1=0, buf_trunc=0, FSM=WAIT, bank=0. byte_rdy=1 in first cycle after rst_n release.
- All outputs registered. Byte accepted in cycle N -> RAM write strobe (cena=0) in cycle N+1; strobe is one cycle.
- Last byte accepted in N: write in N+1, byte_rdy=0 in N+1 (CLOSE), buf_full[b]=1 and buf_len valid from N+2; byte_rdy=1 in N+2 if next bank FREE.
- buf_free[b] in cycle M: buf_full[b]=0 in M+1; if FSM waiting on b, byte_rdy=1 in M+1.
- Reset asserted mid-page: all state cleared immediately, partial page discarded, no RAM strobe.

## Configuration
- NFC_WBUF_PACK_EN defined: even byte latched in pack register, no write; odd byte writes full word (wena=2'b00, dina={odd,even}) at N+1. On close with odd byte_cnt, CLOSE cycle writes pending low byte (wena=2'b10).
- Undefined: every byte written individually, dina={byte,byte}, wena=2'b10 for even lane, 2'b01 for odd lane; CLOSE performs no write.

## Test plan
- Reset release, 4 bytes 0x11,0x22,0x33,0x44 with last on 0x44 -> writes at addr 0/1 (packed: words 0x2211,0x4433); buf_full=2'b01, buf_len0=4 at N+2.
- 3-byte page 0xA1,0xB2,0xC3 in bank 1 -> last write addr 2305 low lane (wena=2'b10), buf_len1=3.
- 4608 bytes without byte_last -> auto-close, buf_trunc[0]=1, buf_len0=4608, final addr 2303.
- Two pages with no buf_free, third page offered -> byte_rdy=0 held; buf_free=2'b01 -> byte_rdy=1 next cycle, write resumes at addr 0.
- rst_n low mid-page after 10 bytes -> cena=1, buf_full=0 immediately; next page writes from addr 0.
- buf_free to FREE bank and simultaneous 2'b11 with both FULL -> ignored / both cleared next cycle.
